w5500_udp_framer: RTL

//  Transmit-side counterpart of the W5500 receive buffer. Buffers video bytes (clk_50M domain), then emits

---
 rtl/w5500_pkg.sv | 36 +++
 rtl/byte_fifo_sc.sv | 57 +++++
 rtl/w5500_udp_framer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/w5500_pkg.sv
// rtl/w5500_pkg.sv - shared types and constants for the W5500 UDP transmit framer
package w5500_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAY,
        WAIT_DONE
    } state_t;

    localparam int          HDR_BYTES    = 8;
    localparam logic [31:0] DEF_DST_IP   = 32'hC0A8011E;
    localparam logic [15:0] DEF_DST_PORT = 16'd5000;

    // Header byte at position idx: IP (4, MSB first), port (2), payload length (2).
    function automatic logic [7:0] hdr_byte(
        input logic [31:0] ip,
        input logic [15:0] port,
        input logic [15:0] len,
        input logic [2:0]  idx
    );
        logic [7:0] b;
        case (idx)
            3'd0:    b = ip[31:24];
            3'd1:    b = ip[23:16];
            3'd2:    b = ip[15:8];
            3'd3:    b = ip[7:0];
            3'd4:    b = port[15:8];
            3'd5:    b = port[7:0];
            3'd6:    b = len[15:8];
            default: b = len[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/byte_fifo_sc.sv
// rtl/byte_fifo_sc.sv - single-clock byte FIFO with registered 1-cycle read
//
// Ports:
//   clk_50M, rst       clock, synchronous active-high reset (pointers only, RAM not cleared)
//   wr_en, wr_data     write strobe and byte; ignored while full
//   rd_en              pop request; rd_data holds the popped byte from the next cycle on
//   rd_data            registered read data, held until the next pop
//   level              bytes stored (ADDR_W+1 bits)
//   full               level == 2**ADDR_W
module byte_fifo_sc #(
    parameter int ADDR_W = 11
) (
    input  logic              clk_50M,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    output logic [7:0]        rd_data,
    output logic [ADDR_W:0]   level,
    output logic              full
);

    logic [7:0]      mem [2**ADDR_W];
    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic            wr_fire;
    logic            rd_fire;

    // The extra pointer bit makes level 2**ADDR_W distinguishable from empty.
    assign level   = wr_ptr - rd_ptr;
    assign full    = level[ADDR_W];
    assign wr_fire = wr_en && !full;
    assign rd_fire = rd_en && (level != '0);

    always_ff @(posedge clk_50M) begin
        if (wr_fire) begin
            mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr[ADDR_W-1:0]];
            end
        end
    end

endmodule

// File: rtl/w5500_udp_framer.sv
// rtl/w5500_udp_framer.sv - buffers payload bytes and emits W5500 UDP frames (IP, port, len, payload)
//
// Optional feature macro: W5500_FRAMER_TIMEOUT_FLUSH_EN (idle timeout auto-flush, adds TIMEOUT_CYC).
//
// Ports:
//   clk_50M, rst   clock, synchronous active-high reset (drops buffered bytes, also mid-frame)
//   in_nd, in_data payload byte strobe and byte
//   flush          pulse: send buffered bytes as a short frame
//   tx_ready       downstream accepts tx_data this cycle
//   tx_done        pulse: W5500 finished sending the current frame
//   tx_valid       tx_data valid (held with tx_data until accepted)
//   tx_data        header/payload byte
//   tx_frame       high from first header byte offered until last payload byte accepted
//   tx_len         payload length of current frame
//   fifo_level     bytes buffered
//   overflow       sticky: an input byte was dropped because the buffer was full
//   frame_cnt      frames completed (tx_done seen in WAIT_DONE)
module w5500_udp_framer
    import w5500_pkg::*;
#(
    parameter int          ADDR_W   = 11,
    parameter int          PKT_LEN  = 1316,
    parameter logic [31:0] DST_IP   = DEF_DST_IP,
    parameter logic [15:0] DST_PORT = DEF_DST_PORT
`ifdef W5500_FRAMER_TIMEOUT_FLUSH_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 50000
`endif
) (
    input  logic              clk_50M,
    input  logic              rst,
    input  logic              in_nd,
    input  logic [7:0]        in_data,
    input  logic              flush,
    input  logic              tx_ready,
    input  logic              tx_done,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_frame,
    output logic [15:0]       tx_len,
    output logic [ADDR_W:0]   fifo_level,
    output logic              overflow,
    output logic [15:0]       frame_cnt
);

    localparam logic [15:0] PKT_LEN_W = 16'(PKT_LEN);
    localparam logic [2:0]  HDR_LAST  = 3'(HDR_BYTES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  hdr_idx;
    logic [15:0] rd_left;
    logic        pay_valid;
    logic        flush_pend;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        full;
    logic [15:0] level16;
    logic        start;
    logic        start_fire;
    logic        timeout_hit;

    byte_fifo_sc #(
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk_50M (clk_50M),
        .rst     (rst),
        .wr_en   (in_nd),
        .wr_data (in_data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .level   (fifo_level),
        .full    (full)
    );

    assign level16    = 16'(fifo_level);
    assign start      = (level16 >= PKT_LEN_W) || (flush_pend && (level16 != 16'd0));
    assign start_fire = (state == IDLE) && start;

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tx_valid  = 1'b0;
        tx_data   = 8'd0;
        tx_frame  = 1'b0;
        rd_en     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = HDR;
                end
            end
            HDR: begin
                tx_valid = 1'b1;
                tx_frame = 1'b1;
                tx_data  = hdr_byte(DST_IP, DST_PORT, tx_len, hdr_idx);
                if (tx_ready && (hdr_idx == HDR_LAST)) begin
                    // Prefetch the first payload byte so it is ready on entry to PAY.
                    rd_en     = 1'b1;
                    state_nxt = PAY;
                end
            end
            PAY: begin
                tx_frame = 1'b1;
                tx_valid = pay_valid;
                tx_data  = rd_data;
                // Refill the output byte when it is empty or being taken this cycle.
                if ((rd_left != 16'd0) && (!pay_valid || tx_ready)) begin
                    rd_en = 1'b1;
                end
                if (pay_valid && tx_ready && (rd_left == 16'd0)) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            hdr_idx    <= '0;
            rd_left    <= '0;
            pay_valid  <= 1'b0;
            flush_pend <= 1'b0;
            tx_len     <= '0;
            overflow   <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            // rd_data only changes on a pop, so a pending byte stays stable until accepted.
            pay_valid <= rd_en || (pay_valid && !tx_ready);

            if (rd_en) begin
                rd_left <= rd_left - 16'd1;
            end

            if (start_fire) begin
                hdr_idx <= '0;
                tx_len  <= (level16 >= PKT_LEN_W) ? PKT_LEN_W : level16;
                rd_left <= (level16 >= PKT_LEN_W) ? PKT_LEN_W : level16;
            end else if ((state == HDR) && tx_ready) begin
                hdr_idx <= hdr_idx + 3'd1;
            end

            // A flush arriving while a frame starts stays pending so leftover bytes follow.
            if (flush && !((state == IDLE) && (level16 == 16'd0))) begin
                flush_pend <= 1'b1;
            end else if (start_fire) begin
                flush_pend <= 1'b0;
            end else if (timeout_hit) begin
                flush_pend <= 1'b1;
            end

            if (in_nd && full) begin
                overflow <= 1'b1;
            end

            if ((state == WAIT_DONE) && tx_done) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

`ifdef W5500_FRAMER_TIMEOUT_FLUSH_EN
    logic [31:0] idle_cnt;

    // Saturates at TIMEOUT_CYC; the frame start that follows clears it.
    always_ff @(posedge clk_50M) begin
        if (rst || in_nd || start_fire) begin
            idle_cnt <= '0;
        end else if ((state == IDLE) && (level16 != 16'd0) && (idle_cnt != 32'(TIMEOUT_CYC))) begin
            idle_cnt <= idle_cnt + 32'd1;
        end
    end

    assign timeout_hit = (idle_cnt == 32'(TIMEOUT_CYC));
`else
    assign timeout_hit = 1'b0;
`endif

endmodule
